sd_adc: RTL and testbench
=========================

SD_ADC -- requirements
Module: sd_adc

Interface
REQ-001 SHALL have parameter BITDEPTH, default 14, meaning PCM output width.
REQ-002 SHALL have parameter SAMPLECLOCK_DIV, default 8, meaning log2 of clk cycles per sample window.
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sample_clock  input  1  sample tick from the sample clock divider, sampled in the clk domain.
REQ-006 SHALL have port comp_in  input  1  external comparator output (asynchronous).
REQ-007 SHALL have port fb_out  output  1  sigma-delta feedback drive to the RC integrator.
REQ-008 SHALL have port pcm  output  BITDEPTH  unsigned decoded sample.
REQ-009 SHALL have port pcm_valid  output  1  sample available.
REQ-010 SHALL have port pcm_ready  input  1  consumer accepts the sample.
REQ-011 SHALL have port overrun  output  1  sticky flag: a sample was dropped.
REQ-012 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-013 SHALL pass comp_in through a 2-flop synchroniser; comp_s is the second flop.
REQ-014 SHALL register fb_out <= comp_s every clk, forming a first-order modulator loop.
REQ-015 SHALL detect a rising edge of sample_clock with a 1-flop delay compare; edge = sc & ~sc_d.
REQ-016 SHALL use FSM states SYNC and ACCUM; reset enters SYNC.
REQ-017 SHALL in SYNC ignore comp_s, hold the ones counter at 0, and move to ACCUM on the first edge, so the partial window is discarded.
REQ-018 SHALL in ACCUM increment a SAMPLECLOCK_DIV+1 bit ones counter on each clk with comp_s=1, saturating at 2**SAMPLECLOCK_DIV.
REQ-019 SHALL on edge in ACCUM saturate the count to 2**SAMPLECLOCK_DIV-1 and left-shift it by BITDEPTH-SAMPLECLOCK_DIV to form the new sample, and restart the counter in that same cycle (0, or 1 if comp_s=1).
REQ-020 SHALL with default parameters map all-ones to 16320 and all-zeros to 0.
REQ-021 SHALL present a new sample on pcm/pcm_valid 1 clk after the edge cycle.
REQ-022 SHALL complete a transfer on any clk where pcm_valid & pcm_ready; pcm_valid then falls next clk unless a new sample is loaded in the same cycle.
REQ-023 SHALL hold pcm stable while pcm_valid & ~pcm_ready.
REQ-024 SHALL on a new sample while pcm_valid & ~pcm_ready keep the old pcm, drop the new sample, and set overrun.
REQ-025 SHALL on a new sample in the same cycle as a transfer load the new sample, keep pcm_valid high, and leave overrun unchanged.
REQ-026 SHALL clear overrun on overrun_clr; if a drop occurs in the same cycle, set wins.
REQ-027 SHALL accept windows of any length: a short window yields a smaller count, and a long window saturates per REQ-018.

Reset
REQ-028 SHALL on rst=0 at posedge clk set pcm=0, pcm_valid=0, overrun=0, fb_out=0, clear the counter and synchroniser flops, and enter SYNC.
REQ-029 SHALL on reset asserted mid-window or with pcm_valid pending discard all state; no sample may be emitted until the second sample_clock edge after release.

Structure
REQ-030 SHALL place the FSM state encoding and the default BITDEPTH/SAMPLECLOCK_DIV constants in the shared audio package, alongside the synth chain constants.
REQ-031 SHALL use one sub-module, sd_window_counter (saturating ones counter with restart), instantiated once; the handshake and FSM stay in sd_adc.

Verification
REQ-032 SHALL cover: comp_in=1 constant, pcm_ready=1, sample_clock every 256 clk -> first pcm_valid after the 2nd edge with pcm=16320, then every 256 clk.
REQ-033 SHALL cover: comp_in toggling every clk -> pcm=128<<6=8192 (+/-64) each window.
REQ-034 SHALL cover: pcm_ready=0 across 2 windows -> pcm holds the first value, overrun=1; overrun_clr pulse -> overrun=0.
REQ-035 SHALL cover: pcm_ready=1 exactly in the edge+1 cycle of the next sample -> new pcm loaded, pcm_valid stays 1, overrun=0.
REQ-036 SHALL cover: rst=0 for 1 clk mid-window with pcm_valid=1 -> next clk all outputs 0; next sample only after the 2nd subsequent edge.
REQ-037 SHALL cover: window stretched to 400 clk with comp_in=1 -> pcm=16320 (saturated), no counter wrap.

Source files
------------

// File: rtl/sd_adc_pkg.sv
// Shared audio constants and the sigma-delta ADC state encoding.
package sd_adc_pkg;

   // Default PCM width and log2 of clk cycles per sample window
   localparam int unsigned BITDEPTH_DEF        = 14;
   localparam int unsigned SAMPLECLOCK_DIV_DEF = 8;

   // SYNC discards the partial window after reset; ACCUM counts ones per window
   typedef enum logic {
      SYNC  = 1'b0,
      ACCUM = 1'b1
   } sd_state_e;

endpackage

// File: rtl/sd_window_counter.sv
// Saturating ones counter for one sample window, with hold-at-zero and restart.
module sd_window_counter import sd_adc_pkg::*; #(
   parameter int unsigned SAMPLECLOCK_DIV = SAMPLECLOCK_DIV_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hold_i,
   input  logic                     restart_i,
   input  logic                     inc_i,
   output logic [SAMPLECLOCK_DIV:0] count_o
);

   localparam logic [SAMPLECLOCK_DIV:0] CNT_MAX = {1'b1, {SAMPLECLOCK_DIV{1'b0}}};
   localparam logic [SAMPLECLOCK_DIV:0] CNT_ONE = {{SAMPLECLOCK_DIV{1'b0}}, 1'b1};

   logic [SAMPLECLOCK_DIV:0] count_q;
   logic [SAMPLECLOCK_DIV:0] count_d;

   // Restart loads the current bit so the edge cycle belongs to the new window
   always_comb begin
      count_d = count_q;
      if (hold_i) begin
         count_d = '0;
      end else if (restart_i) begin
         count_d = {{SAMPLECLOCK_DIV{1'b0}}, inc_i};
      end else if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/sd_adc.sv
// First-order sigma-delta ADC: comparator sync, feedback, window decimation, PCM handshake.
module sd_adc import sd_adc_pkg::*; #(
   parameter int unsigned BITDEPTH        = BITDEPTH_DEF,
   parameter int unsigned SAMPLECLOCK_DIV = SAMPLECLOCK_DIV_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_clock,
   input  logic                comp_in,
   output logic                fb_out,
   output logic [BITDEPTH-1:0] pcm,
   output logic                pcm_valid,
   input  logic                pcm_ready,
   output logic                overrun,
   input  logic                overrun_clr
);

   localparam int unsigned                 SHIFT   = BITDEPTH - SAMPLECLOCK_DIV;
   localparam logic [SAMPLECLOCK_DIV-1:0]  WIN_MAX = '1;

   logic                     comp_m_q, comp_s_q, fb_q;
   logic                     sc_q, sc_d_q;
   sd_state_e                state_q, state_d;
   logic [BITDEPTH-1:0]      pcm_q, pcm_d;
   logic                     valid_q, valid_d;
   logic                     ovr_q, ovr_d;
   logic [SAMPLECLOCK_DIV:0] count;
   logic [SAMPLECLOCK_DIV-1:0] win_sat_c;
   logic [BITDEPTH-1:0]      sample_c;
   logic                     tick_c, new_sample_c, transfer_c, drop_c;

   assign tick_c       = sc_q & ~sc_d_q;
   assign new_sample_c = tick_c && (state_q == ACCUM);
   assign transfer_c   = valid_q & pcm_ready;

   // A count of 2**DIV only happens with the MSB alone set, so MSB means saturate
   assign win_sat_c = count[SAMPLECLOCK_DIV] ? WIN_MAX : count[SAMPLECLOCK_DIV-1:0];
   assign sample_c  = BITDEPTH'(win_sat_c) << SHIFT;

   sd_window_counter #(
      .SAMPLECLOCK_DIV (SAMPLECLOCK_DIV)
   ) u_win_cnt (
      .clk       (clk),
      .rst       (rst),
      .hold_i    (state_q == SYNC),
      .restart_i (tick_c),
      .inc_i     (comp_s_q),
      .count_o   (count)
   );

   // Next state and handshake: a new sample loads only if the slot is free or draining
   always_comb begin
      state_d = state_q;
      pcm_d   = pcm_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      drop_c  = 1'b0;
      case (state_q)
         SYNC:    if (tick_c) state_d = ACCUM;
         ACCUM:   state_d = ACCUM;
         default: state_d = SYNC;
      endcase
      if (new_sample_c) begin
         if (!valid_q || transfer_c) begin
            pcm_d   = sample_c;
            valid_d = 1'b1;
         end else begin
            drop_c = 1'b1;
         end
      end else if (transfer_c) begin
         valid_d = 1'b0;
      end
      if (drop_c)           ovr_d = 1'b1;
      else if (overrun_clr) ovr_d = 1'b0;
   end

   // Synchroniser, modulator feedback, tick detector and FSM/handshake registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         comp_m_q <= 1'b0;
         comp_s_q <= 1'b0;
         fb_q     <= 1'b0;
         sc_q     <= 1'b0;
         sc_d_q   <= 1'b0;
         state_q  <= SYNC;
         pcm_q    <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         comp_m_q <= comp_in;
         comp_s_q <= comp_m_q;
         fb_q     <= comp_s_q;
         sc_q     <= sample_clock;
         sc_d_q   <= sc_q;
         state_q  <= state_d;
         pcm_q    <= pcm_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign fb_out    = fb_q;
   assign pcm       = pcm_q;
   assign pcm_valid = valid_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_sd_adc.sv
// Self-checking bench for sd_adc: directed window scenarios plus randomized traffic.
module tb_sd_adc;

   logic        clk;
   logic        rst;
   logic        sample_clock;
   logic        comp_in;
   logic        fb_out;
   logic [13:0] pcm;
   logic        pcm_valid;
   logic        pcm_ready;
   logic        overrun;
   logic        overrun_clr;

   int passed = 0;
   int total  = 0;

   // Reference model: input history per posedge index and abstract handshake state
   bit comp_h [0:16383];
   bit sc_h   [0:16383];
   int n = 4;
   int win_lo = 0;
   bit m_synced = 0;
   bit m_valid = 0;
   int m_pcm = 0;
   bit m_ov = 0;

   logic [31:0] snap_pcm;
   logic        snap_valid;

   sd_adc dut (
      .clk          (clk),
      .rst          (rst),
      .sample_clock (sample_clock),
      .comp_in      (comp_in),
      .fb_out       (fb_out),
      .pcm          (pcm),
      .pcm_valid    (pcm_valid),
      .pcm_ready    (pcm_ready),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, n);
   endtask

   task automatic chk_range(input string tag, input logic [31:0] obs,
                            input logic [31:0] lo, input logic [31:0] hi);
      total++;
      assert (!$isunknown(obs) && obs >= lo && obs <= hi) passed++;
      else $error("FAIL %s: observed %0d expected %0d..%0d (cycle %0d)", tag, obs, lo, hi, n);
   endtask

   // One clk: drive at negedge, advance the model at posedge, compare 1 time unit later.
   // A window's value is the number of comp_in ones it saw, clipped to 255, times 64.
   task automatic step(input logic c, input logic s, input logic r, input logic cl, input logic rs);
      bit tick, load, transfer, drop;
      int sum, samp;
      @(negedge clk);
      comp_in = c; sample_clock = s; pcm_ready = r; overrun_clr = cl; rst = rs;
      @(posedge clk);
      n++;
      comp_h[n] = c;
      sc_h[n]   = s;
      if (!rs) begin
         comp_h[n] = 1'b0; comp_h[n-1] = 1'b0; sc_h[n] = 1'b0;
         m_valid = 1'b0; m_pcm = 0; m_ov = 1'b0; m_synced = 1'b0;
      end else begin
         tick = sc_h[n-1] && !sc_h[n-2];
         load = 1'b0;
         samp = 0;
         if (tick) begin
            if (!m_synced) begin
               m_synced = 1'b1;
               win_lo = n - 1;
            end else begin
               sum = 0;
               for (int k = win_lo; k <= n - 3; k++) sum += int'(comp_h[k]);
               if (sum > 255) sum = 255;
               samp = sum * 64;
               load = 1'b1;
               win_lo = n - 2;
            end
         end
         transfer = m_valid && r;
         drop = 1'b0;
         if (load) begin
            if (!m_valid || transfer) begin
               m_pcm = samp;
               m_valid = 1'b1;
            end else begin
               drop = 1'b1;
            end
         end else if (transfer) begin
            m_valid = 1'b0;
         end
         if (drop)    m_ov = 1'b1;
         else if (cl) m_ov = 1'b0;
      end
      #1;
      chk("fb_out",    32'(fb_out),    rs ? 32'(comp_h[n-2]) : 32'd0);
      chk("pcm",       32'(pcm),       32'(m_pcm));
      chk("pcm_valid", 32'(pcm_valid), 32'(m_valid));
      chk("overrun",   32'(overrun),   32'(m_ov));
   endtask

   // cmode: 0 zeros, 1 ones, 2 toggle, 3 random; rmode: 0 low, 1 high, 2 random, 3 only at index 1
   task automatic window(input int len, input int cmode, input int rmode, input int clr_at);
      logic c, r;
      for (int i = 0; i < len; i++) begin
         case (cmode)
            0:       c = 1'b0;
            1:       c = 1'b1;
            2:       c = 1'(n % 2);
            default: c = 1'($urandom % 2);
         endcase
         case (rmode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            2:       r = 1'($urandom % 2);
            default: r = (i == 1);
         endcase
         step(c, (i == 0), r, (i == clr_at), 1'b1);
         if (i == 1) begin
            snap_pcm   = 32'(pcm);
            snap_valid = pcm_valid;
         end
      end
   endtask

   initial begin
      rst = 1'b0; sample_clock = 1'b0; comp_in = 1'b0; pcm_ready = 1'b0; overrun_clr = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Constant ones, always ready: first sample only after the second tick
      window(256, 1, 1, -1);
      chk("t1_first_tick_no_sample", 32'(snap_valid), 32'd0);
      for (int w = 0; w < 4; w++) begin
         window(256, 1, 1, -1);
         chk("t1_valid", 32'(snap_valid), 32'd1);
         chk("t1_full_scale", snap_pcm, 32'd16320);
      end

      // Toggling comparator: mid-scale
      window(256, 2, 1, -1);
      for (int w = 0; w < 3; w++) begin
         window(256, 2, 1, -1);
         chk_range("t2_mid_scale", snap_pcm, 32'd8128, 32'd8256);
      end

      // Consumer stalled across two further windows: hold and overrun
      window(256, 3, 0, -1);
      window(256, 3, 0, -1);
      window(256, 3, 0, -1);
      chk("t3_overrun_set", 32'(overrun), 32'd1);
      chk("t3_valid_held", 32'(pcm_valid), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("t3_overrun_cleared", 32'(overrun), 32'd0);

      // Transfer in the same cycle the next sample loads
      window(256, 3, 3, -1);
      chk("t4_valid_kept", 32'(snap_valid), 32'd1);
      chk("t4_no_overrun", 32'(overrun), 32'd0);

      // Reset mid-window with a sample pending
      chk("t5_pending_before_reset", 32'(pcm_valid), 32'd1);
      for (int i = 0; i < 100; i++) step(1'($urandom % 2), 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_reset_pcm", 32'(pcm), 32'd0);
      chk("t5_reset_valid", 32'(pcm_valid), 32'd0);
      window(256, 1, 1, -1);
      chk("t5_first_tick_no_sample", 32'(snap_valid), 32'd0);
      window(256, 3, 1, -1);
      chk("t5_second_tick_sample", 32'(snap_valid), 32'd1);

      // Stretched window saturates, then a short window
      window(400, 1, 1, -1);
      window(100, 3, 1, -1);
      chk("t6_stretched_saturates", snap_pcm, 32'd16320);
      window(200, 0, 1, -1);
      chk("t6_short_window_valid", 32'(snap_valid), 32'd1);

      // Randomized windows, stalls and clears
      for (int w = 0; w < 12; w++) begin
         window(int'($urandom_range(40, 300)), 3, 2, ($urandom % 3 == 0) ? 20 : -1);
      end
      window(64, 0, 1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
